ift_vector_player: RTL and testbench

- Synthesisable, parametrised replay engine for value/taint stimulus vectors.
- Drives NUM_CH value bits plus one TAINT_W-bit taint label per channel into an IFT-instrumented DUT.
- Vectors are preloaded into an internal table; each entry carries its own hold duration.
- Successor to file-driven tb stimulus: adds channel/width/depth parameters, a loop mode, abort, a start/busy/done handshake and per-channel taint-active flags.

---
 rtl/ift_vector_player.sv | 162 ++++++++++++++++
 tb/tb_ift_vector_player.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ift_vector_player.sv
// Replays preloaded value/taint vectors, one table entry per hold period, into an
// information-flow-tracking DUT. Supports loop, abort and a start/busy/done handshake.
module ift_vector_player #(
    parameter int NUM_CH  = 2,
    parameter int TAINT_W = 32,
    parameter int DEPTH   = 96,
    parameter int HOLD_W  = 32,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ENTRY_W = NUM_CH + NUM_CH*TAINT_W + HOLD_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [ENTRY_W-1:0]        wr_data,
    input  logic                      start,
    input  logic [ADDR_W:0]           num_entries,
    input  logic                      loop_en,
    input  logic                      abort,
    output logic [NUM_CH-1:0]         val_out,
    output logic [NUM_CH*TAINT_W-1:0] taint_out,
    output logic [NUM_CH-1:0]         taint_act,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         entry_idx
);

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY
    } state_t;

    state_t                    state_reg;
    logic [ADDR_W:0]           n_reg;
    logic [ADDR_W-1:0]         idx_reg;
    logic [HOLD_W-1:0]         hold_cnt_reg;
    logic [NUM_CH-1:0]         val_reg;
    logic [NUM_CH*TAINT_W-1:0] taint_reg;
    logic                      busy_reg;
    logic                      done_reg;

    logic [ENTRY_W-1:0]        table_mem [DEPTH];
    logic [ENTRY_W-1:0]        rd_data_reg;
    logic [ADDR_W-1:0]         rd_addr;

    logic [NUM_CH-1:0]         rd_val;
    logic [NUM_CH*TAINT_W-1:0] rd_taint;
    logic [HOLD_W-1:0]         rd_hold;
    logic [HOLD_W-1:0]         rd_hold_eff;
    logic [ADDR_W:0]           n_latch;
    logic                      expire;
    logic                      is_last;

    // Successor index within the latched play length, wrapping to 0 after the last entry.
    function automatic logic [ADDR_W-1:0] nxt_of(input logic [ADDR_W-1:0] i,
                                                 input logic [ADDR_W:0]   n);
        if ({1'b0, i} == n - (ADDR_W+1)'(1))
            return '0;
        else
            return i + ADDR_W'(1);
    endfunction

    assign rd_val      = rd_data_reg[ENTRY_W-1 -: NUM_CH];
    assign rd_taint    = rd_data_reg[HOLD_W +: NUM_CH*TAINT_W];
    assign rd_hold     = rd_data_reg[HOLD_W-1:0];
    assign rd_hold_eff = (rd_hold == '0) ? HOLD_W'(1) : rd_hold;
    assign n_latch     = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
    assign expire      = (hold_cnt_reg == HOLD_W'(1));
    assign is_last     = ({1'b0, idx_reg} == n_reg - (ADDR_W+1)'(1));

    // The read register always holds the entry that will be presented at the next load,
    // so the address looks one entry ahead of whatever is being loaded this edge.
    always_comb begin
        rd_addr = '0;
        case (state_reg)
            S_FETCH: rd_addr = nxt_of('0, n_reg);
            S_PLAY:  rd_addr = expire ? nxt_of(nxt_of(idx_reg, n_reg), n_reg)
                                      : nxt_of(idx_reg, n_reg);
            default: rd_addr = '0;
        endcase
    end

    // Table write and registered read; a same-edge write to the read address yields old data.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_N))
            table_mem[wr_addr] <= wr_data;
        rd_data_reg <= table_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            idx_reg      <= '0;
            hold_cnt_reg <= '0;
            val_reg      <= '0;
            taint_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        n_reg <= n_latch;
                        if (n_latch == '0)
                            done_reg <= 1'b1;
                        else
                            state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                    end else begin
                        val_reg      <= rd_val;
                        taint_reg    <= rd_taint;
                        hold_cnt_reg <= rd_hold_eff;
                        idx_reg      <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (abort || (expire && is_last && !loop_en)) begin
                        val_reg      <= '0;
                        taint_reg    <= '0;
                        idx_reg      <= '0;
                        hold_cnt_reg <= '0;
                        busy_reg     <= 1'b0;
                        done_reg     <= !abort;
                        state_reg    <= S_IDLE;
                    end else if (!expire) begin
                        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                    end else begin
                        val_reg      <= rd_val;
                        taint_reg    <= rd_taint;
                        hold_cnt_reg <= rd_hold_eff;
                        idx_reg      <= nxt_of(idx_reg, n_reg);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_act
            assign taint_act[gi] = |taint_reg[gi*TAINT_W +: TAINT_W];
        end
    endgenerate

    assign val_out   = val_reg;
    assign taint_out = taint_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign entry_idx = idx_reg;

endmodule

// File: tb/tb_ift_vector_player.sv
// Scoreboard bench for ift_vector_player: a default instance plus a 4-channel/8-bit/16-deep one.
module tb_ift_vector_player;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance (NUM_CH=2, TAINT_W=32, DEPTH=96)
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [97:0] wr_data;
    logic        start;
    logic [7:0]  num_entries;
    logic        loop_en;
    logic        abort;
    logic [1:0]  val_out;
    logic [63:0] taint_out;
    logic [1:0]  taint_act;
    logic        busy;
    logic        done;
    logic [6:0]  entry_idx;

    ift_vector_player dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .num_entries(num_entries), .loop_en(loop_en), .abort(abort),
        .val_out(val_out), .taint_out(taint_out), .taint_act(taint_act),
        .busy(busy), .done(done), .entry_idx(entry_idx)
    );

    // Narrow instance (NUM_CH=4, TAINT_W=8, DEPTH=16)
    logic        wr_en4;
    logic [3:0]  wr_addr4;
    logic [67:0] wr_data4;
    logic        start4;
    logic [4:0]  num_entries4;
    logic        loop_en4;
    logic        abort4;
    logic [3:0]  val_out4;
    logic [31:0] taint_out4;
    logic [3:0]  taint_act4;
    logic        busy4;
    logic        done4;
    logic [3:0]  entry_idx4;

    ift_vector_player #(.NUM_CH(4), .TAINT_W(8), .DEPTH(16)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .start(start4), .num_entries(num_entries4), .loop_en(loop_en4), .abort(abort4),
        .val_out(val_out4), .taint_out(taint_out4), .taint_act(taint_act4),
        .busy(busy4), .done(done4), .entry_idx(entry_idx4)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [6:0]  idx;
        logic [3:0]  val;
        logic [63:0] taint;
        logic [3:0]  act;
    } snap_t;

    snap_t q[$];
    snap_t q4[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: every cycle with a pending expectation is one comparison.
    initial begin
        snap_t e;
        snap_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{busy: busy, done: done, idx: entry_idx, val: {2'b00, val_out},
                      taint: taint_out, act: {2'b00, taint_act}};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL dut_cycle t=%0t: got busy=%b done=%b idx=%0d val=%h taint=%h act=%b, want busy=%b done=%b idx=%0d val=%h taint=%h act=%b",
                             $time, a.busy, a.done, a.idx, a.val, a.taint, a.act,
                             e.busy, e.done, e.idx, e.val, e.taint, e.act);
                end
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                a = '{busy: busy4, done: done4, idx: {3'b000, entry_idx4}, val: val_out4,
                      taint: {32'h0, taint_out4}, act: taint_act4};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL dut4_cycle t=%0t: got busy=%b done=%b idx=%0d val=%h taint=%h act=%b, want busy=%b done=%b idx=%0d val=%h taint=%h act=%b",
                             $time, a.busy, a.done, a.idx, a.val, a.taint, a.act,
                             e.busy, e.done, e.idx, e.val, e.taint, e.act);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [97:0] mk(logic [1:0] v, logic [31:0] t1, logic [31:0] t0,
                                       logic [31:0] h);
        return {v, t1, t0, h};
    endfunction

    task automatic wr(int addr, logic [97:0] data);
        wr_en = 1'b1; wr_addr = 7'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr4(int addr, logic [67:0] data);
        wr_en4 = 1'b1; wr_addr4 = 4'(addr); wr_data4 = data;
        tick();
        wr_en4 = 1'b0;
    endtask

    task automatic exp_idle(int n);
        for (int i = 0; i < n; i++) q.push_back('0);
    endtask

    task automatic exp_done();
        snap_t s;
        s = '0;
        s.done = 1'b1;
        q.push_back(s);
    endtask

    task automatic exp_e(int idx, logic [1:0] v, logic [31:0] t1, logic [31:0] t0, int n);
        snap_t s;
        s.busy  = 1'b1;
        s.done  = 1'b0;
        s.idx   = 7'(idx);
        s.val   = {2'b00, v};
        s.taint = {t1, t0};
        s.act   = {2'b00, |t1, |t0};
        for (int i = 0; i < n; i++) q.push_back(s);
    endtask

    task automatic exp4(logic b, logic d, int idx, logic [3:0] v, logic [31:0] t,
                        logic [3:0] act, int n);
        snap_t s;
        s = '{busy: b, done: d, idx: 7'(idx), val: v, taint: {32'h0, t}, act: act};
        for (int i = 0; i < n; i++) q4.push_back(s);
    endtask

    // Let the monitor consume all expectations, within a bounded number of cycles.
    task automatic drain(string name);
        for (int i = 0; i < 400 && (q.size() > 0 || q4.size() > 0); i++) tick();
        if (q.size() > 0 || q4.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_%s: %0d/%0d expectations left, want 0", name, q.size(), q4.size());
            q.delete();
            q4.delete();
        end
    endtask

    logic [1:0]  d_val [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    logic [31:0] d_t1  [6] = '{32'd1, 32'd0, 32'd4, 32'd0, 32'd8, 32'd0};
    logic [31:0] d_t0  [6] = '{32'd0, 32'd2, 32'd4, 32'd0, 32'd0, 32'd16};

    initial begin
        rst = 1'b1;
        wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; num_entries = '0; loop_en = 0; abort = 0;
        wr_en4 = 0; wr_addr4 = '0; wr_data4 = '0; start4 = 0; num_entries4 = '0; loop_en4 = 0; abort4 = 0;
        tick(); tick();
        $display("TXN reset: outputs idle while rst held");
        exp_idle(2);
        exp4(0, 0, 0, 4'h0, 32'h0, 4'h0, 2);
        drain("reset");
        rst = 1'b0;

        // Six-entry sequence with hold 8 each
        for (int k = 0; k < 6; k++) wr(k, mk(d_val[k], d_t1[k], d_t0[k], 32'd8));
        $display("TXN defaults: 6 entries, hold 8, no loop");
        start = 1; num_entries = 8'd6; loop_en = 0;
        exp_idle(2);
        for (int k = 0; k < 6; k++) exp_e(k, d_val[k], d_t1[k], d_t0[k], 8);
        exp_done();
        exp_idle(1);
        tick(); start = 0;
        drain("defaults");

        $display("TXN abort in third playback cycle");
        start = 1; num_entries = 8'd6;
        exp_idle(2);
        exp_e(0, d_val[0], d_t1[0], d_t0[0], 3);
        exp_idle(3);
        tick(); start = 0;
        tick(); tick(); tick();
        abort = 1;
        tick(); abort = 0;
        drain("abort");

        $display("TXN reset in third playback cycle");
        start = 1; num_entries = 8'd6;
        exp_idle(2);
        exp_e(0, d_val[0], d_t1[0], d_t0[0], 3);
        exp_idle(3);
        tick(); start = 0;
        tick(); tick(); tick();
        rst = 1;
        tick(); rst = 0;
        drain("midreset");

        $display("TXN start with abort in idle");
        start = 1; abort = 1; num_entries = 8'd6;
        exp_idle(4);
        tick(); start = 0; abort = 0;
        drain("start_abort");

        // Holds 0,1,3 -> 1,1,3 cycles
        wr(0, mk(2'd1, 32'd0, 32'd5, 32'd0));
        wr(1, mk(2'd2, 32'd6, 32'd0, 32'd1));
        wr(2, mk(2'd3, 32'd7, 32'd7, 32'd3));
        $display("TXN holds 0,1,3");
        start = 1; num_entries = 8'd3;
        exp_idle(2);
        exp_e(0, 2'd1, 32'd0, 32'd5, 1);
        exp_e(1, 2'd2, 32'd6, 32'd0, 1);
        exp_e(2, 2'd3, 32'd7, 32'd7, 3);
        exp_done();
        exp_idle(1);
        tick(); start = 0;
        drain("holds");

        // Loop over two entries, then release loop during entry 1
        wr(0, mk(2'd1, 32'd0, 32'd9, 32'd2));
        wr(1, mk(2'd2, 32'd3, 32'd0, 32'd2));
        $display("TXN loop N=2 holds 2,2");
        start = 1; num_entries = 8'd2; loop_en = 1;
        exp_idle(2);
        for (int r = 0; r < 3; r++) begin
            exp_e(0, 2'd1, 32'd0, 32'd9, 2);
            exp_e(1, 2'd2, 32'd3, 32'd0, 2);
        end
        exp_done();
        exp_idle(1);
        tick(); start = 0;
        for (int i = 0; i < 11; i++) tick();
        loop_en = 0;
        drain("loop");

        $display("TXN num_entries=0");
        start = 1; num_entries = 8'd0;
        exp_idle(1);
        exp_done();
        exp_idle(2);
        tick(); start = 0;
        drain("zero");

        // Rewrite entry 1 while entry 0 is on the outputs
        wr(0, mk(2'd1, 32'h11, 32'h22, 32'd4));
        wr(1, mk(2'd2, 32'h33, 32'h0, 32'd2));
        $display("TXN write entry 1 during entry 0");
        start = 1; num_entries = 8'd2;
        exp_idle(2);
        exp_e(0, 2'd1, 32'h11, 32'h22, 4);
        exp_e(1, 2'd3, 32'h0, 32'h44, 2);
        exp_done();
        exp_idle(1);
        tick(); start = 0;
        tick();
        wr(1, mk(2'd3, 32'h0, 32'h44, 32'd2));
        drain("live_write");

        wr(96, mk(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9));
        wr(97, mk(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9));
        wr(127, mk(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9));
        $display("TXN out-of-range writes ignored");
        start = 1; num_entries = 8'd2;
        exp_idle(2);
        exp_e(0, 2'd1, 32'h11, 32'h22, 4);
        exp_e(1, 2'd3, 32'h0, 32'h44, 2);
        exp_done();
        exp_idle(1);
        tick(); start = 0;
        drain("oob_write");

        for (int k = 0; k < 96; k++) wr(k, mk(2'(k), 32'(k*3), 32'(k), 32'd0));
        $display("TXN num_entries=DEPTH+5");
        start = 1; num_entries = 8'd101;
        exp_idle(2);
        for (int k = 0; k < 96; k++) exp_e(k, 2'(k), 32'(k*3), 32'(k), 1);
        exp_done();
        exp_idle(1);
        tick(); start = 0;
        drain("overlength");

        // Packing {val[3:0], t3, t2, t1, t0, hold}; ch0 label lands in taint_out[7:0]
        wr4(0, {4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 32'd2});
        wr4(1, {4'b0100, 8'h00, 8'h3C, 8'h00, 8'h00, 32'd1});
        wr4(2, {4'b1010, 8'h80, 8'h00, 8'h01, 8'h00, 32'd1});
        $display("TXN 4-channel instance, 3 entries");
        start4 = 1; num_entries4 = 5'd3;
        exp4(0, 0, 0, 4'h0, 32'h0, 4'h0, 2);
        exp4(1, 0, 0, 4'b0001, 32'h0000_00A5, 4'b0001, 2);
        exp4(1, 0, 1, 4'b0100, 32'h003C_0000, 4'b0100, 1);
        exp4(1, 0, 2, 4'b1010, 32'h8000_0100, 4'b1010, 1);
        exp4(0, 1, 0, 4'h0, 32'h0, 4'h0, 1);
        exp4(0, 0, 0, 4'h0, 32'h0, 4'h0, 1);
        tick(); start4 = 0;
        drain("dut4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
